cpu_scoreboard: RTL

CPU_SCOREBOARD -- requirements
Module: cpu_scoreboard

---
 rtl/cpu_scoreboard_pkg.sv | 15 +
 rtl/cpu_scoreboard_if.sv | 37 +++
 rtl/cpu_scoreboard_bits.sv | 60 ++++++
 rtl/cpu_scoreboard.sv | 83 ++++++++
 4 files changed

// File: rtl/cpu_scoreboard_pkg.sv
// Shared CPU definitions: register index width and scoreboard FSM states.
// Imported by the scoreboard as well as the forwarding and decode stages.
package cpu_scoreboard_pkg;

  localparam int REG_IDX_W = 6;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } sb_state_e;

endpackage

// File: rtl/cpu_scoreboard_if.sv
// Decode/writeback <-> scoreboard signal bundle.
// Decode drives through master; the scoreboard takes the slave side.
interface cpu_scoreboard_if import cpu_scoreboard_pkg::*; ();

  logic        i_query_valid;
  reg_idx_t    i_rs1;
  reg_idx_t    i_rs2;
  reg_idx_t    i_rs3;
  logic        i_rs1_en;
  logic        i_rs2_en;
  logic        i_rs3_en;
  reg_idx_t    i_rd;
  logic        i_rd_en;
  logic        i_issue_long;
  logic        i_complete_valid;
  reg_idx_t    i_complete_rd;
  logic        i_flush;
  logic        i_fence;
  logic        o_stall;
  logic        o_busy;
  logic [31:0] o_stall_count;

  modport master (
    output i_query_valid, i_rs1, i_rs2, i_rs3, i_rs1_en, i_rs2_en, i_rs3_en,
           i_rd, i_rd_en, i_issue_long, i_complete_valid, i_complete_rd,
           i_flush, i_fence,
    input  o_stall, o_busy, o_stall_count
  );

  modport slave (
    input  i_query_valid, i_rs1, i_rs2, i_rs3, i_rs1_en, i_rs2_en, i_rs3_en,
           i_rd, i_rd_en, i_issue_long, i_complete_valid, i_complete_rd,
           i_flush, i_fence,
    output o_stall, o_busy, o_stall_count
  );

endinterface

// File: rtl/cpu_scoreboard_bits.sv
// Pending-register vector: per-register set/clear plus hazard lookup.
// Lookups see the vector after this cycle's completion is cleared, since
// forwarding supplies the writeback value in that same cycle.
module cpu_scoreboard_bits import cpu_scoreboard_pkg::*; #(
  parameter int NREGS = 64
) (
  input  logic     i_clock,
  input  logic     i_reset,
  input  logic     i_flush,
  input  logic     i_set_en,
  input  reg_idx_t i_set_rd,
  input  logic     i_clr_en,
  input  reg_idx_t i_clr_rd,
  input  logic     i_query_valid,
  input  reg_idx_t i_rs1,
  input  reg_idx_t i_rs2,
  input  reg_idx_t i_rs3,
  input  logic     i_rs1_en,
  input  logic     i_rs2_en,
  input  logic     i_rs3_en,
  input  reg_idx_t i_rd,
  input  logic     i_rd_en,
  output logic     o_hazard,
  output logic     o_busy,
  output logic     o_empty_next
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] pending_byp;

  // Build set/clear masks, the bypassed view, the hazard and the next vector.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (i_clr_en)                   clr_mask[i_clr_rd] = 1'b1;
    if (i_set_en && i_set_rd != '0) set_mask[i_set_rd] = 1'b1;
    pending_byp = pending_q & ~clr_mask;
    o_hazard = i_query_valid &&
               ((i_rs1_en && pending_byp[i_rs1]) ||
                (i_rs2_en && pending_byp[i_rs2]) ||
                (i_rs3_en && pending_byp[i_rs3]) ||
                (i_rd_en  && pending_byp[i_rd]));
    if (i_flush) pending_d = '0;
    else         pending_d = pending_byp | set_mask;
    pending_d[0] = 1'b0;
  end

  assign o_busy       = |pending_q;
  assign o_empty_next = ~|pending_d;

  // Pending vector register; reset drops every in-flight entry.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) pending_q <= '0;
    else         pending_q <= pending_d;
  end

endmodule

// File: rtl/cpu_scoreboard.sv
// Register scoreboard for long-latency ops: stalls decode on RAW/WAW hazards
// and drains all in-flight long ops before a fence proceeds.
module cpu_scoreboard import cpu_scoreboard_pkg::*; #(
  parameter int NREGS = 64
) (
  input  logic           i_clock,
  input  logic           i_reset,
  cpu_scoreboard_if.slave sb
);

  sb_state_e   state_q;
  sb_state_e   state_d;
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;
  logic        hazard;
  logic        busy;
  logic        empty_next;
  logic        stall;
  logic        issue;

  assign stall = hazard || (state_q == DRAIN);
  assign issue = sb.i_query_valid && !stall && sb.i_rd_en && sb.i_issue_long;

  cpu_scoreboard_bits #(.NREGS(NREGS)) u_bits (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_flush       (sb.i_flush),
    .i_set_en      (issue),
    .i_set_rd      (sb.i_rd),
    .i_clr_en      (sb.i_complete_valid),
    .i_clr_rd      (sb.i_complete_rd),
    .i_query_valid (sb.i_query_valid),
    .i_rs1         (sb.i_rs1),
    .i_rs2         (sb.i_rs2),
    .i_rs3         (sb.i_rs3),
    .i_rs1_en      (sb.i_rs1_en),
    .i_rs2_en      (sb.i_rs2_en),
    .i_rs3_en      (sb.i_rs3_en),
    .i_rd          (sb.i_rd),
    .i_rd_en       (sb.i_rd_en),
    .o_hazard      (hazard),
    .o_busy        (busy),
    .o_empty_next  (empty_next)
  );

  // Next FSM state and saturating stall counter; flush forces RUN.
  always_comb begin
    state_d       = state_q;
    stall_count_d = stall_count_q;
    unique case (state_q)
      RUN: begin
        if (sb.i_fence && busy) state_d = DRAIN;
        else if (hazard)        state_d = STALL;
      end
      STALL: begin
        if (sb.i_fence && busy) state_d = DRAIN;
        else if (!hazard)       state_d = RUN;
      end
      DRAIN: begin
        if (empty_next) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (sb.i_flush) state_d = RUN;
    if (stall && stall_count_q != 32'hFFFF_FFFF) stall_count_d = stall_count_q + 32'd1;
  end

  // FSM state and stall counter registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= RUN;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign sb.o_stall       = stall;
  assign sb.o_busy        = busy;
  assign sb.o_stall_count = stall_count_q;

endmodule
